// File: rtl/mem_pkg.sv
// Shared constants and types for the byte-lane scratch memory and its access unit.
package mem_pkg;

  localparam int unsigned ADDR_WIDTH       = 32;
  localparam int unsigned DATA_WIDTH_BYTES = 4;
  localparam int unsigned MEM_SIZE_BYTES   = 4096;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  // Bytes touched by an access; the illegal encoding maps to 4 but is faulted separately.
  function automatic logic [2:0] size_nbytes(logic [1:0] size);
    case (size)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Core request/response channel plus the byte-lane memory bus of the access unit.
interface mem_access_unit_if;
  import mem_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_rdata;
  logic                  rsp_fault;

  logic                  mem_wenableL [DATA_WIDTH_BYTES];
  logic [7:0]            mem_data_w   [DATA_WIDTH_BYTES];
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [7:0]            mem_data_r   [DATA_WIDTH_BYTES];

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready, mem_data_r,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault, mem_wenableL, mem_data_w, mem_addr
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready, mem_data_r,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault, mem_wenableL, mem_data_w, mem_addr
  );

endinterface

// File: rtl/load_extend.sv
// Assembles the used read lanes into a 32-bit value with sign or zero extension.
module load_extend
  import mem_pkg::*;
(
  input  logic [7:0]  lanes [DATA_WIDTH_BYTES],
  input  size_e       size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic ext;

  always_comb begin
    ext  = 1'b0;
    data = '0;
    unique case (size)
      SIZE_B: begin
        ext  = ~is_unsigned & lanes[0][7];
        data = {{24{ext}}, lanes[0]};
      end
      SIZE_H: begin
        ext  = ~is_unsigned & lanes[1][7];
        data = {{16{ext}}, lanes[1], lanes[0]};
      end
      SIZE_W:  data = {lanes[3], lanes[2], lanes[1], lanes[0]};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator: accepts core requests, drives byte lanes, returns extended load data.
module mem_access_unit
  import mem_pkg::*;
(
  input logic              clk,
  input logic              rstL,
  mem_access_unit_if.slave bus
);

  localparam int unsigned SumWidth = ADDR_WIDTH + 1;

  state_e                state_q, state_d;
  size_e                 size_q;
  logic                  unsigned_q;
  logic                  we_q;
  logic [31:0]           rdata_q;
  logic                  fault_q;
  logic                  wen_q   [DATA_WIDTH_BYTES];
  logic                  wen_d   [DATA_WIDTH_BYTES];
  logic [7:0]            wdata_q [DATA_WIDTH_BYTES];
  logic [ADDR_WIDTH-1:0] addr_q;

  logic                  accept;
  logic [2:0]            nbytes;
  logic [SumWidth-1:0]   end_addr;
  logic                  fault_req;
  logic [31:0]           ext_data;

  assign accept    = bus.req_valid && (state_q == StIdle);
  assign nbytes    = size_nbytes(bus.req_size);
  // One extra bit so addr + nbytes cannot wrap past the bounds check.
  assign end_addr  = {1'b0, bus.req_addr} + SumWidth'(nbytes);
  assign fault_req = (bus.req_size == 2'b11) || (end_addr > SumWidth'(MEM_SIZE_BYTES));

  always_comb begin
    for (int i = 0; i < DATA_WIDTH_BYTES; i++) begin
      wen_d[i] = !(bus.req_we && (i < int'(nbytes)));
    end
  end

  always_ff @(posedge clk or negedge rstL) begin
    if (!rstL) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = fault_req ? StResp : StIssue;
      StIssue: state_d = we_q ? StResp : StWait;
      StWait:  state_d = StResp;
      StResp:  if (bus.rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstL) begin
    if (!rstL) begin
      size_q     <= SIZE_B;
      unsigned_q <= 1'b0;
      we_q       <= 1'b0;
      rdata_q    <= '0;
      fault_q    <= 1'b0;
      addr_q     <= '0;
      for (int i = 0; i < DATA_WIDTH_BYTES; i++) begin
        wen_q[i]   <= 1'b1;
        wdata_q[i] <= 8'h00;
      end
    end else begin
      if (accept) begin
        if (fault_req) begin
          fault_q <= 1'b1;
          rdata_q <= '0;
        end else begin
          addr_q     <= bus.req_addr;
          size_q     <= size_e'(bus.req_size);
          unsigned_q <= bus.req_unsigned;
          we_q       <= bus.req_we;
          for (int i = 0; i < DATA_WIDTH_BYTES; i++) begin
            wen_q[i]   <= wen_d[i];
            wdata_q[i] <= bus.req_wdata[8*i +: 8];
          end
        end
      end
      // Write strobes are held for exactly the one cycle the memory samples them.
      if (state_q == StIssue) begin
        for (int i = 0; i < DATA_WIDTH_BYTES; i++) wen_q[i] <= 1'b1;
        if (we_q) begin
          rdata_q <= '0;
          fault_q <= 1'b0;
        end
      end
      if (state_q == StWait) begin
        rdata_q <= ext_data;
        fault_q <= 1'b0;
      end
    end
  end

  load_extend u_load_extend (
    .lanes       (bus.mem_data_r),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .data        (ext_data)
  );

  assign bus.req_ready    = (state_q == StIdle);
  assign bus.rsp_valid    = (state_q == StResp);
  assign bus.rsp_rdata    = rdata_q;
  assign bus.rsp_fault    = fault_q;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_wenableL = wen_q;
  assign bus.mem_data_w   = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed table, reset sequence and randomized traffic vs a byte model.
module tb_mem_access_unit;
  import mem_pkg::*;

  localparam int IW = $clog2(MEM_SIZE_BYTES);

  logic clk = 1'b0;
  logic rstL;
  always #5 clk = ~clk;

  mem_access_unit_if bus ();

  mem_access_unit dut (
    .clk  (clk),
    .rstL (rstL),
    .bus  (bus)
  );

  logic [7:0]  mem     [MEM_SIZE_BYTES] = '{default: 8'h00};
  logic [7:0]  ref_mem [MEM_SIZE_BYTES] = '{default: 8'h00};
  int unsigned write_count = 0;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic logic [DATA_WIDTH_BYTES-1:0] wen_vec();
    logic [DATA_WIDTH_BYTES-1:0] v;
    for (int i = 0; i < DATA_WIDTH_BYTES; i++) v[i] = bus.mem_wenableL[i];
    return v;
  endfunction

  function automatic int unsigned low_lanes();
    int unsigned c = 0;
    for (int i = 0; i < DATA_WIDTH_BYTES; i++) if (!bus.mem_wenableL[i]) c++;
    return c;
  endfunction

  // Scratch memory: lane i at addr+i, registered read, active-low byte writes.
  always @(posedge clk) begin
    for (int i = 0; i < DATA_WIDTH_BYTES; i++) begin
      if (64'(bus.mem_addr) + 64'(i) < 64'(MEM_SIZE_BYTES)) begin
        if (!bus.mem_wenableL[i]) mem[IW'(bus.mem_addr + 32'(i))] <= bus.mem_data_w[i];
        bus.mem_data_r[i] <= mem[IW'(bus.mem_addr + 32'(i))];
      end else begin
        bus.mem_data_r[i] <= 8'h00;
      end
    end
    write_count <= write_count + low_lanes();
  end

  function automatic int unsigned nbytes_of(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  // Reference: byte array semantics, arithmetic sign extension.
  function automatic void model(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rdata, output logic fault, output int lat);
    int unsigned    n = nbytes_of(size);
    longint unsigned v = 0;
    rdata = '0;
    fault = (size == 2'b11) || (64'(addr) + 64'(n) > 64'(MEM_SIZE_BYTES));
    if (fault) begin
      lat = 1;
      return;
    end
    if (we) begin
      for (int k = 0; k < int'(n); k++) ref_mem[IW'(addr + 32'(k))] = wdata[8*k +: 8];
      lat = 2;
    end else begin
      for (int k = 0; k < int'(n); k++) v += longint'(ref_mem[IW'(addr + 32'(k))]) << (8 * k);
      if (!uns && v >= (64'd1 << (8 * n - 1))) v = v + (64'd1 << 32) - (64'd1 << (8 * n));
      rdata = v[31:0];
      lat = 3;
    end
  endfunction

  task automatic check(input string tag, input string what, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s %s: got %h expected %h", tag, what, act, exp);
    end
  endtask

  task automatic transact(input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input int stall, input logic [31:0] exp_rdata, input logic exp_fault,
                          input int exp_lat);
    int n = 0;
    int lat;
    int unsigned wc0;
    int unsigned exp_wr;
    logic [31:0] rd;
    logic ft;
    logic stable = 1'b1;
    logic [DATA_WIDTH_BYTES-1:0] exp_wen = '1;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size; bus.req_unsigned = uns;
    bus.req_addr = addr; bus.req_wdata = wdata; bus.rsp_ready = (stall == 0);
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      check(tag, "accept_timeout", 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    wc0 = write_count;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_we = 1'($urandom); bus.req_size = 2'($urandom);
    bus.req_unsigned = 1'($urandom); bus.req_addr = $urandom; bus.req_wdata = $urandom;
    exp_wr = 0;
    if (we && !exp_fault) begin
      exp_wr = nbytes_of(size);
      for (int i = 0; i < int'(exp_wr); i++) exp_wen[i] = 1'b0;
    end
    check(tag, "issue_wen", 32'(wen_vec()), 32'(exp_wen));
    lat = 1;
    while (!bus.rsp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = bus.rsp_rdata;
    ft = bus.rsp_fault;
    check(tag, "latency", 32'(lat), 32'(exp_lat));
    check(tag, "rdata", rd, exp_rdata);
    check(tag, "fault", 32'(ft), 32'(exp_fault));
    if (stall > 0) begin
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== rd || bus.rsp_fault !== ft ||
            bus.req_ready !== 1'b0) stable = 1'b0;
      end
      check(tag, "hold_stable", 32'(stable), 32'd1);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check(tag, "back_to_idle", {30'd0, bus.rsp_valid, bus.req_ready}, 32'b01);
    check(tag, "lanes_written", write_count - wc0, exp_wr);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          stall;
    logic [31:0] exp_rdata;
    logic        exp_fault;
    int          exp_lat;
  } vec_t;

  vec_t tbl [20];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] m_rd;
    logic        m_ft;
    int          m_lat;
    int unsigned wc0;

    tbl[0]  = '{1'b1, 2'b10, 1'b0, 32'h10,       32'hDEADBEEF, 0, 32'h0,        1'b0, 2};
    tbl[1]  = '{1'b0, 2'b10, 1'b0, 32'h10,       32'h0,        0, 32'hDEADBEEF, 1'b0, 3};
    tbl[2]  = '{1'b1, 2'b10, 1'b0, 32'h20,       32'h11223344, 0, 32'h0,        1'b0, 2};
    tbl[3]  = '{1'b1, 2'b00, 1'b0, 32'h21,       32'hA5A5A580, 0, 32'h0,        1'b0, 2};
    tbl[4]  = '{1'b0, 2'b00, 1'b0, 32'h21,       32'h0,        0, 32'hFFFFFF80, 1'b0, 3};
    tbl[5]  = '{1'b0, 2'b00, 1'b1, 32'h21,       32'h0,        0, 32'h00000080, 1'b0, 3};
    tbl[6]  = '{1'b0, 2'b10, 1'b0, 32'h20,       32'h0,        0, 32'h11228044, 1'b0, 3};
    tbl[7]  = '{1'b1, 2'b01, 1'b0, 32'h33,       32'h77778001, 0, 32'h0,        1'b0, 2};
    tbl[8]  = '{1'b0, 2'b01, 1'b0, 32'h33,       32'h0,        0, 32'hFFFF8001, 1'b0, 3};
    tbl[9]  = '{1'b0, 2'b01, 1'b1, 32'h33,       32'h0,        5, 32'h00008001, 1'b0, 3};
    tbl[10] = '{1'b0, 2'b10, 1'b0, 32'hFFE,      32'h0,        0, 32'h0,        1'b1, 1};
    tbl[11] = '{1'b1, 2'b11, 1'b0, 32'h0,        32'hFFFFFFFF, 0, 32'h0,        1'b1, 1};
    tbl[12] = '{1'b1, 2'b00, 1'b0, 32'hFFF,      32'h0000007F, 0, 32'h0,        1'b0, 2};
    tbl[13] = '{1'b0, 2'b00, 1'b0, 32'hFFF,      32'h0,        0, 32'h0000007F, 1'b0, 3};
    tbl[14] = '{1'b1, 2'b01, 1'b0, 32'hFFF,      32'h12345678, 0, 32'h0,        1'b1, 1};
    tbl[15] = '{1'b0, 2'b10, 1'b0, 32'hFFC,      32'h0,        0, 32'h7F000000, 1'b0, 3};
    tbl[16] = '{1'b0, 2'b01, 1'b0, 32'h10,       32'h0,        0, 32'hFFFFBEEF, 1'b0, 3};
    tbl[17] = '{1'b0, 2'b00, 1'b0, 32'h13,       32'h0,        2, 32'hFFFFFFDE, 1'b0, 3};
    tbl[18] = '{1'b0, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h0,        0, 32'h0,        1'b1, 1};
    tbl[19] = '{1'b1, 2'b10, 1'b0, 32'h0,        32'h00C0FFEE, 3, 32'h0,        1'b0, 2};

    rstL = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset", "req_ready", 32'(bus.req_ready), 32'd1);
    check("reset", "rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset", "rsp_rdata", bus.rsp_rdata, 32'd0);
    check("reset", "rsp_fault", 32'(bus.rsp_fault), 32'd0);
    check("reset", "mem_wenableL", 32'(wen_vec()), 32'hF);
    check("reset", "mem_addr", bus.mem_addr, 32'd0);
    check("reset", "mem_data_w", {bus.mem_data_w[3], bus.mem_data_w[2], bus.mem_data_w[1],
                                  bus.mem_data_w[0]}, 32'd0);
    @(negedge clk);
    rstL = 1'b1;

    for (int v = 0; v < 20; v++) begin
      model(tbl[v].we, tbl[v].size, tbl[v].uns, tbl[v].addr, tbl[v].wdata, m_rd, m_ft, m_lat);
      transact($sformatf("vec%0d", v), tbl[v].we, tbl[v].size, tbl[v].uns, tbl[v].addr,
               tbl[v].wdata, tbl[v].stall, tbl[v].exp_rdata, tbl[v].exp_fault, tbl[v].exp_lat);
    end

    // Async reset in the middle of a store's ISSUE cycle must kill the write.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b10; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h40; bus.req_wdata = 32'hCAFEBABE; bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("rst_mid", "issue_wen", 32'(wen_vec()), 32'h0);
    #2 rstL = 1'b0;
    #1;
    check("rst_mid", "wen_async", 32'(wen_vec()), 32'hF);
    check("rst_mid", "rsp_valid_async", 32'(bus.rsp_valid), 32'd0);
    check("rst_mid", "req_ready_async", 32'(bus.req_ready), 32'd1);
    wc0 = write_count;
    @(posedge clk); #1;
    check("rst_mid", "no_write", write_count - wc0, 32'd0);
    @(negedge clk);
    rstL = 1'b1;
    #1;
    check("rst_mid", "req_ready_after", 32'(bus.req_ready), 32'd1);
    model(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, m_rd, m_ft, m_lat);
    transact("rst_mid_load", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 0, 32'h0, 1'b0, 3);

    for (int r = 0; r < 150; r++) begin
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          stall;
      we    = 1'($urandom);
      size  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      uns   = 1'($urandom);
      addr  = ($urandom_range(0, 4) == 0) ? 32'(MEM_SIZE_BYTES - $urandom_range(1, 6))
                                          : 32'($urandom_range(0, 63));
      wdata = $urandom;
      stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      model(we, size, uns, addr, wdata, m_rd, m_ft, m_lat);
      transact($sformatf("rand%0d", r), we, size, uns, addr, wdata, stall, m_rd, m_ft, m_lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
